mem_wb_pipe_reg: RTL

- Parametrised MEM/WB pipeline stage register for the datapath.
- Carries writeback control (jump, mem_to_reg, reg_write) plus read data, ALU result and destination register from the MEM stage to the WB stage.
- Adds what a bare clocked latch lacks: valid/ready handshake, a 2-entry skid buffer so backpressure never drops an instruction, and a synchronous flush for bubble insertion.

---
 rtl/mem_wb_pipe_reg_pkg.sv | 42 ++++
 rtl/mem_wb_pipe_reg_if.sv | 57 +++++
 rtl/mem_wb_pipe_reg_skid.sv | 101 ++++++++++
 rtl/mem_wb_pipe_reg.sv | 83 ++++++++
 4 files changed

// File: rtl/mem_wb_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_pkg
//   Shared types for the MEM/WB stage register and its skid-buffer core.
//   - default width localparams for the datapath
//   - skid buffer occupancy enum
//   - payload struct at default widths
//   - payload_w(): packed payload width for a given parameterisation
// Optional feature macro: MEM_WB_WBDATA_EN (adds the pre-muxed wb_data field).
// ---------------------------------------------------------------------------
package mem_wb_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic                      jump;
    logic                      mem_to_reg;
    logic                      reg_write;
    logic [DATA_W_DEF-1:0]     read_data;
    logic [DATA_W_DEF-1:0]     alu_result;
    logic [REG_ADDR_W_DEF-1:0] write_reg;
`ifdef MEM_WB_WBDATA_EN
    logic [DATA_W_DEF-1:0]     wb_data;
`endif
  } mem_wb_payload_t;

  function automatic int unsigned payload_w(input int unsigned dw,
                                            input int unsigned aw);
`ifdef MEM_WB_WBDATA_EN
    return 3 + 3 * dw + aw;
`else
    return 3 + 2 * dw + aw;
`endif
  endfunction

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe_reg_if
//   Bundle of the MEM->WB handshake, payload and flush signals.
//   slave  : stage register view (consumes *_i, in_valid, out_ready, flush;
//            drives in_ready, out_valid, *_o)
//   master : surrounding pipeline view (the opposite directions)
// Optional feature macro: MEM_WB_WBDATA_EN (adds wb_data_o).
// ---------------------------------------------------------------------------
interface mem_wb_pipe_reg_if
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) ();

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  jump_i;
  logic                  mem_to_reg_i;
  logic                  reg_write_i;
  logic [DATA_W-1:0]     read_data_i;
  logic [DATA_W-1:0]     alu_result_i;
  logic [REG_ADDR_W-1:0] write_reg_i;
  logic                  out_valid;
  logic                  out_ready;
  logic                  jump_o;
  logic                  mem_to_reg_o;
  logic                  reg_write_o;
  logic [DATA_W-1:0]     read_data_o;
  logic [DATA_W-1:0]     alu_result_o;
  logic [REG_ADDR_W-1:0] write_reg_o;
`ifdef MEM_WB_WBDATA_EN
  logic [DATA_W-1:0]     wb_data_o;
`endif

  modport slave (
    input  flush, in_valid, jump_i, mem_to_reg_i, reg_write_i,
           read_data_i, alu_result_i, write_reg_i, out_ready,
    output in_ready, out_valid, jump_o, mem_to_reg_o, reg_write_o,
           read_data_o, alu_result_o, write_reg_o
`ifdef MEM_WB_WBDATA_EN
           , wb_data_o
`endif
  );

  modport master (
    output flush, in_valid, jump_i, mem_to_reg_i, reg_write_i,
           read_data_i, alu_result_i, write_reg_i, out_ready,
    input  in_ready, out_valid, jump_o, mem_to_reg_o, reg_write_o,
           read_data_o, alu_result_o, write_reg_o
`ifdef MEM_WB_WBDATA_EN
           , wb_data_o
`endif
  );

endinterface

// File: rtl/mem_wb_pipe_reg_skid.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
//   Generic 2-entry valid/ready skid buffer, FIFO ordered, payload-agnostic.
//   in_ready_o is registered (never combinational on out_ready_i).
//   flush_i synchronously empties the buffer and overrides accept/consume.
// Ports:
//   clk, rst_n (async active-low), flush_i
//   in_valid_i / in_ready_o / in_data_i   : upstream side
//   out_valid_o / out_ready_i / out_data_o: downstream side (main register)
// ---------------------------------------------------------------------------
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q, state_d;
  logic         in_ready_q;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q;
  logic         load_main, load_skid;
  logic         accept, consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_d;
      if (load_skid) skid_q <= in_data_i;
    end
  end

  always_comb begin
    accept    = in_valid_i & in_ready_q;
    consume   = (state_q != EMPTY) & out_ready_i;
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_d    = in_data_i;
    if (flush_i) begin
      // Main register keeps its contents so data outputs hold their last value.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (accept && consume) begin
            load_main = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so nothing new can arrive this cycle.
          if (consume) begin
            state_d   = ONE;
            load_main = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid_o = (state_q != EMPTY);
    in_ready_o  = in_ready_q;
    out_data_o  = main_q;
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe_reg
//   MEM/WB pipeline stage register with valid/ready handshake, 2-entry skid
//   buffer and synchronous flush. Payload is packed into a pipe_skid_buf.
// Ports:
//   clk   : stage clock
//   rst_n : asynchronous active-low reset
//   pipe  : mem_wb_pipe_reg_if.slave (flush, in_valid/in_ready, *_i,
//           out_valid/out_ready, *_o)
// Control outputs (jump/mem_to_reg/reg_write) read 0 whenever out_valid=0;
// data outputs hold their last value.
// Optional feature macro: MEM_WB_WBDATA_EN adds wb_data_o, the writeback mux
// result registered at load time.
// ---------------------------------------------------------------------------
module mem_wb_pipe_reg
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_wb_pipe_reg_if.slave pipe
);

  typedef struct packed {
    logic                  jump;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] write_reg;
`ifdef MEM_WB_WBDATA_EN
    logic [DATA_W-1:0]     wb_data;
`endif
  } payload_t;

  localparam int unsigned PW = payload_w(DATA_W, REG_ADDR_W);

  payload_t in_pl, out_pl;
  logic     out_valid;

  always_comb begin
    in_pl            = '0;
    in_pl.jump       = pipe.jump_i;
    in_pl.mem_to_reg = pipe.mem_to_reg_i;
    in_pl.reg_write  = pipe.reg_write_i;
    in_pl.read_data  = pipe.read_data_i;
    in_pl.alu_result = pipe.alu_result_i;
    in_pl.write_reg  = pipe.write_reg_i;
`ifdef MEM_WB_WBDATA_EN
    in_pl.wb_data    = pipe.mem_to_reg_i ? pipe.read_data_i : pipe.alu_result_i;
`endif
  end

  pipe_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (pipe.flush),
    .in_valid_i  (pipe.in_valid),
    .in_ready_o  (pipe.in_ready),
    .in_data_i   (in_pl),
    .out_valid_o (out_valid),
    .out_ready_i (pipe.out_ready),
    .out_data_o  (out_pl)
  );

  always_comb begin
    pipe.out_valid    = out_valid;
    pipe.jump_o       = out_valid & out_pl.jump;
    pipe.mem_to_reg_o = out_valid & out_pl.mem_to_reg;
    pipe.reg_write_o  = out_valid & out_pl.reg_write;
    pipe.read_data_o  = out_pl.read_data;
    pipe.alu_result_o = out_pl.alu_result;
    pipe.write_reg_o  = out_pl.write_reg;
`ifdef MEM_WB_WBDATA_EN
    pipe.wb_data_o    = out_pl.wb_data;
`endif
  end

endmodule
